// File: rtl/ecc_pkg.sv
// Shared SEC-DED (extended Hamming) definitions: width codes, per-mode geometry
// and the encode function also used by the decoder.
`timescale 1ns/1ps
package ecc_pkg;

  localparam int ECC_W = 32;

  localparam logic [1:0] CW_SMALL   = 2'b00;
  localparam logic [1:0] CW_MEDIUM  = 2'b01;
  localparam logic [1:0] CW_LARGE   = 2'b10;
  localparam logic [1:0] CW_ILLEGAL = 2'b11;

  localparam int R_SMALL  = 3;
  localparam int R_MEDIUM = 4;
  localparam int R_LARGE  = 5;
  localparam int K_SMALL  = 4;
  localparam int K_MEDIUM = 11;
  localparam int K_LARGE  = 26;
  localparam int CW_SMALL_BITS  = 8;
  localparam int CW_MEDIUM_BITS = 16;
  localparam int CW_LARGE_BITS  = 32;

  function automatic logic [2:0] ecc_check_bits(input logic [1:0] width);
    case (width)
      CW_SMALL:  return 3'd3;
      CW_MEDIUM: return 3'd4;
      CW_LARGE:  return 3'd5;
      default:   return 3'd0;
    endcase
  endfunction

  // Highest Hamming position in use (2^r - 1); 0 disables encoding.
  function automatic logic [4:0] ecc_pos_max(input logic [1:0] width);
    case (width)
      CW_SMALL:  return 5'd7;
      CW_MEDIUM: return 5'd15;
      CW_LARGE:  return 5'd31;
      default:   return 5'd0;
    endcase
  endfunction

  function automatic logic [ECC_W-1:0] ecc_width_mask(input logic [1:0] width);
    case (width)
      CW_SMALL:  return 32'h0000_00FF;
      CW_MEDIUM: return 32'h0000_FFFF;
      CW_LARGE:  return 32'hFFFF_FFFF;
      default:   return 32'h0000_0000;
    endcase
  endfunction

  // Data bit d_i sits at the i-th non-power-of-two position; that ordering is a
  // common prefix for every mode, so one walk serves as the position table.
  function automatic logic [ECC_W-1:0] ecc_encode(input logic [ECC_W-1:0] data,
                                                  input logic [1:0]       width);
    logic [ECC_W-1:0] cw;
    logic [4:0]       syn;
    logic [4:0]       pmax;
    logic [4:0]       p;
    logic [4:0]       di;
    logic [4:0]       idx;
    logic [2:0]       r;
    cw   = '0;
    syn  = '0;
    di   = '0;
    idx  = '0;
    r    = ecc_check_bits(width);
    pmax = ecc_pos_max(width);
    for (int pos = 3; pos < ECC_W; pos++) begin
      p = pos[4:0];
      if (p <= pmax && (p & (p - 5'd1)) != 5'd0) begin
        idx     = {2'b00, r} + 5'd1 + di;
        cw[idx] = data[di];
        syn     = syn ^ (data[di] ? p : 5'd0);
        di      = di + 5'd1;
      end
    end
    cw    = cw | {{(ECC_W-6){1'b0}}, syn, 1'b0};
    cw[0] = ^cw[ECC_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/ecc_fifo.sv
// Synchronous FIFO for encoded words; head is presented combinationally and
// reads as zero when empty. Storage is not reset, only pointers and occupancy.
`timescale 1ns/1ps
module ecc_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ecc_stream_encoder.sv
// Streaming SEC-DED encoder: combinational encode + noise mask on accept,
// result queued in an output FIFO together with its width code.
`timescale 1ns/1ps
module ecc_stream_encoder
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AMBA_WORD-1:0] DATA_IN,
  input  logic [1:0]           CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0] NOISE,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AMBA_WORD-1:0] OUT,
  output logic [1:0]           out_width,
  output logic                 err_illegal,
  output logic [15:0]          words_encoded
);

  logic                 accept, legal, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [ECC_W-1:0]     cw_enc, cw_noisy;
  logic [AMBA_WORD+1:0] fifo_din, fifo_dout;
  logic                 err_q, err_d;
  logic [15:0]          cnt_q, cnt_d;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign legal    = (CODEWORD_WIDTH != CW_ILLEGAL);
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;

  assign cw_enc   = ecc_encode(DATA_IN[ECC_W-1:0], CODEWORD_WIDTH);
  assign cw_noisy = cw_enc ^ (NOISE[ECC_W-1:0] & ecc_width_mask(CODEWORD_WIDTH));
  assign fifo_din = {CODEWORD_WIDTH, AMBA_WORD'(cw_noisy)};

  ecc_fifo #(
    .WIDTH (AMBA_WORD + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid     = !fifo_empty;
  assign OUT           = fifo_dout[AMBA_WORD-1:0];
  assign out_width     = fifo_dout[AMBA_WORD +: 2];
  assign err_illegal   = err_q;
  assign words_encoded = cnt_q;

  always_comb begin
    err_d = accept && !legal;
    cnt_d = cnt_q;
    if (push && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ecc_stream_encoder.sv
// Directed bench for ecc_stream_encoder with a scoreboard queue of expected
// {width, codeword} entries consumed as the DUT hands words out.
`timescale 1ns/1ps
module tb_ecc_stream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] DATA_IN;
  logic [1:0]  CODEWORD_WIDTH;
  logic [31:0] NOISE;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] OUT;
  logic [1:0]  out_width;
  logic        err_illegal;
  logic [15:0] words_encoded;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [33:0] sb_q[$];

  always #5 clk = ~clk;

  ecc_stream_encoder #(.AMBA_WORD(32), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .DATA_IN        (DATA_IN),
    .CODEWORD_WIDTH (CODEWORD_WIDTH),
    .NOISE          (NOISE),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .OUT            (OUT),
    .out_width      (out_width),
    .err_illegal    (err_illegal),
    .words_encoded  (words_encoded)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference built the textbook way: fill a Hamming array, then parity per check position.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] w,
                                        input logic [31:0] n);
    int r, cwb, k, idx;
    logic h[32];
    logic [4:0] c;
    logic [31:0] o;
    r   = (w == 2'b00) ? 3 : (w == 2'b01) ? 4 : 5;
    cwb = 1 << r;
    k   = cwb - 1 - r;
    for (int p = 0; p < 32; p++) h[p] = 1'b0;
    idx = 0;
    for (int p = 1; p < cwb; p++)
      if ((p & (p - 1)) != 0) begin
        h[p] = d[idx];
        idx++;
      end
    c = '0;
    for (int j = 0; j < r; j++)
      for (int p = 1; p < cwb; p++)
        if (((p >> j) & 1) == 1) c[j] = c[j] ^ h[p];
    o = '0;
    for (int i = 0; i < k; i++) o[r + 1 + i] = d[i];
    for (int j = 0; j < r; j++) o[j + 1] = c[j];
    o[0] = ^o;
    for (int i = 0; i < cwb; i++) o[i] = o[i] ^ n[i];
    return o;
  endfunction

  task automatic send(input logic [31:0] d, input logic [1:0] w, input logic [31:0] n,
                      input logic [31:0] exp, output int waits);
    in_valid       = 1'b1;
    DATA_IN        = d;
    CODEWORD_WIDTH = w;
    NOISE          = n;
    waits          = 0;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      if (w != 2'b11) begin
        sb_q.push_back({w, exp});
        exp_cnt++;
      end
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_valid) chk("drain_timeout", 64'd1, 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_out observed=%0h expected=none", OUT);
      end else begin
        e = sb_q.pop_front();
        chk("out_word", 64'(OUT), 64'(e[31:0]));
        chk("out_width", 64'(out_width), 64'(e[33:32]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    logic [31:0] d, n, first_word;
    logic [1:0]  w;

    rst = 1'b1; in_valid = 1'b0; DATA_IN = '0; CODEWORD_WIDTH = '0; NOISE = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(OUT), 64'd0);
    chk("rst_out_width", 64'(out_width), 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_words", 64'(words_encoded), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic vectors with hand-derived codewords
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hF, 2'b00, 32'h0, 32'h0000_00FF, waits);
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_out", 64'(OUT), 64'h0000_00FF);
    chk("lat_width", 64'(out_width), 64'd0);
    send(32'h1, 2'b00, 32'h0, 32'h0000_0017, waits);
    send(32'h7FF, 2'b01, 32'h0, 32'h0000_FFFF, waits);
    send(32'h3FF_FFFF, 2'b10, 32'h0, 32'hFFFF_FFFF, waits);
    send(32'hF, 2'b00, 32'h0000_0101, 32'h0000_00FE, waits);
    send(32'h7FF, 2'b01, 32'hFFFF_0001, 32'h0000_FFFE, waits);
    drain();
    chk("words_basic", 64'(words_encoded), 64'(exp_cnt));

    // Illegal width: handshake completes, nothing queued
    send(32'hABC, 2'b11, 32'h0, 32'h0, waits);
    @(negedge clk);
    chk("illegal_pulse", 64'(err_illegal), 64'd1);
    chk("illegal_no_entry", 64'(out_valid), 64'd0);
    chk("illegal_words", 64'(words_encoded), 64'(exp_cnt));
    @(negedge clk);
    chk("illegal_pulse_end", 64'(err_illegal), 64'd0);

    // Fill to full with consumer stalled, then one pop admits the fifth word
    @(posedge clk); #1;
    out_ready = 1'b0;
    first_word = '0;
    for (int i = 0; i < 4; i++) begin
      d = $urandom; w = 2'($urandom_range(0, 2)); n = 32'h0;
      if (i == 0) first_word = model(d, w, n);
      send(d, w, n, model(d, w, n), waits);
    end
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head", 64'(OUT), 64'(first_word));
    repeat (2) @(negedge clk);
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_head", 64'(OUT), 64'(first_word));
    @(posedge clk); #1;
    out_ready = 1'b1;
    d = 32'h1234_5678; w = 2'b10; n = 32'h8000_0000;
    send(d, w, n, model(d, w, n), waits);
    chk("fifth_after_one_pop", 64'(waits), 64'd1);
    drain();
    chk("words_full", 64'(words_encoded), 64'(exp_cnt));

    // Random legal traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      d = $urandom; w = 2'($urandom_range(0, 2));
      n = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      send(d, w, n, model(d, w, n), waits);
    end
    drain();
    chk("words_random", 64'(words_encoded), 64'(exp_cnt));

    // Mid-operation reset discards queued words
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = $urandom; w = 2'b01; n = 32'h0;
      send(d, w, n, model(d, w, n), waits);
    end
    @(negedge clk);
    chk("pre_rst_words", 64'(words_encoded), 64'(exp_cnt));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out", 64'(OUT), 64'd0);
    chk("mid_rst_width", 64'(out_width), 64'd0);
    chk("mid_rst_words", 64'(words_encoded), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);

    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h1, 2'b00, 32'h0, 32'h0000_0017, waits);
    drain();
    chk("words_after_rst", 64'(words_encoded), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
